uart_rx_fifo: RTL
=================

# uart_rx_fifo

Serial receive front end inside `tt_um_gerson`. It sits directly downstream of the dedicated input pins: it synchronises one `ui_in` bit carrying 8N1 UART traffic, deserialises bytes, and buffers them in a small first-word-fall-through FIFO. The project core drains the FIFO and drives `uo_out` from it. The top level maps `rst = ~rst_n`.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit; even, ≥ 4.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `rx_i`  in  1  asynchronous serial line; idle is high.
- `rd_en`  in  1  pop the head entry this cycle; ignored when `empty`.
- `clr_err`  in  1  clears `frame_err` and `overrun` at the next edge.
- `rd_data`  out  8  head of FIFO (fall-through); forced to 0 while `empty`.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `count`  out  $clog2(DEPTH)+1  number of stored bytes.
- `busy`  out  1  receiver FSM is not in IDLE.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `overrun`  out  1  sticky; a good byte arrived while the FIFO was full and was dropped.

## Operation
- **Synchroniser:** 2-flop on `rx_i` produces `rx_s`. Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. One bit counter, 0..CLKS_PER_BIT-1. Bit index 0..7.
- **IDLE:** when `rx_s`=0, go to START and clear the counter.
- **START:** at count CLKS_PER_BIT/2-1, sample `rx_s` (mid-start).
  - Sample 0: go to DATA.
  - Sample 1: treat as a glitch and return to IDLE.
- **DATA:** sample every CLKS_PER_BIT cycles. Shift bits in LSB first. After bit 7, go to STOP.
- **STOP:** sample after CLKS_PER_BIT cycles.
  - Sample 1: push the byte and return to IDLE.
  - Sample 0: set `frame_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. This covers a break condition and never produces a byte.
- **FIFO:**
  - Circular buffer with `$clog2(DEPTH)`-bit pointers that wrap naturally.
  - `count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- **Push while full:**
  - Without `rd_en`: byte dropped, `overrun` set, FIFO unchanged.
  - With `rd_en` in the same cycle: pop and push both happen, `count` stays at `DEPTH`, no overrun.
- **Pop when empty:** no effect. Pointers, `count` and flags are unchanged.
- **Error flags:** if `clr_err` and a new error occur in the same cycle, the error wins and the flag stays 1.
- **Reset values:** `empty`=1, `full`=0, `count`=0, `rd_data`=0, `busy`=0, `frame_err`=0, `overrun`=0. The FSM is in IDLE and the synchroniser is 1.
- **Reset mid-frame:** aborts the frame and clears the FIFO. The line is re-acquired from IDLE.

## Timing
- Cycle 0 is the first rising edge at which `rx_i` is low. `rx_s` is low from cycle 2.
- Sample points:
  - Mid-start sample at cycle 2+CLKS_PER_BIT/2.
  - Data bit n (n = 0..7) at 2+CLKS_PER_BIT/2+(n+1)·CLKS_PER_BIT.
  - Stop bit at 2+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- Push is registered on the stop-sample edge. `empty`, `count` and `rd_data` update on that same edge.
- With CLKS_PER_BIT=8: byte visible from cycle 78. The FSM is back in IDLE at cycle 78 and can detect the next start edge at cycle 79.
- **Pop:** `rd_en` high at edge k advances the head. The new `rd_data`/`empty` are visible after edge k, with zero-cycle fall-through.
- `busy` is high from the edge entering START through the edge leaving STOP or WAIT_HIGH.

## Test plan
- **Single byte:** reset, then one frame of 0xA5 (CLKS_PER_BIT=8) -> at cycle 78 `empty`=0, `rd_data`=0xA5, `count`=1; after `rd_en` for 1 cycle, `empty`=1 and `rd_data`=0.
- **Glitch:** `rx_i` low for 2 cycles then high -> FSM back in IDLE by cycle 2+CLKS_PER_BIT/2+1, no push, no flags.
- **Framing error:** frame 0x3C with stop bit 0, line held low 30 cycles, then high -> `frame_err`=1, `count`=0, `busy` low only after the line returns high. `clr_err` then clears the flag.
- **Overrun, full FIFO:** send 5 frames 0x01..0x05 with `DEPTH`=4 and no reads -> `full`=1, `count`=4, `overrun`=1. Popping 4 times returns 0x01..0x04.
- **Push+pop at full:** with the FIFO full, pulse `rd_en` on the stop-sample edge of a 0x55 frame -> `count` stays 4, `overrun`=0, and the last entry read is 0x55.
- **Reset mid-frame:** assert `rst` during DATA after 2 bytes are queued -> next cycle `empty`=1, `count`=0, `busy`=0. A following frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a 2-flop input synchroniser and a first-word-fall-through byte FIFO.
// Sticky frame/overrun flags; a new error outranks clr_err in the same cycle.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_i,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     frame_err,
    output logic                     overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    logic sync1_q;
    logic rx_s_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_req;
    logic             frame_set;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             pop;
    logic             push;
    logic             ovr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift right and insert at the top.
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop         = rd_en && (count_q != '0);
        // A full FIFO still accepts a byte when the same cycle frees a slot.
        push        = push_req && ((count_q != DEPTH_C) || pop);
        ovr_set     = push_req && (count_q == DEPTH_C) && !pop;
        wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = pop ? rptr_q + 1'b1 : rptr_q;
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        frame_err_d = frame_set ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
        overrun_d   = ovr_set ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == DEPTH_C);
        count     = count_q;
        rd_data   = empty ? '0 : mem_q[rptr_q];
        busy      = (state_q != S_IDLE);
        frame_err = frame_err_q;
        overrun   = overrun_q;
    end

endmodule
